// File: rtl/sdram_arbiter_if.sv
// Bus bundle between the video/CPU fabric, the sdram_arbiter and the sdram controller.
// The master modport is the arbiter's view; slave is the surrounding fabric and controller.
interface sdram_arbiter_if;
    logic        mem_ready;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_rfsh;
    logic [23:0] mem_a;
    logic [15:0] mem_d;
    logic [15:0] mem_q;

    logic        p0_req;
    logic [23:0] p0_a;
    logic [15:0] p0_q;
    logic        p0_ack;

    logic        p1_req;
    logic        p1_we;
    logic [23:0] p1_a;
    logic [15:0] p1_d;
    logic [15:0] p1_q;
    logic        p1_ack;

    logic        busy;

    modport master (
        input  mem_ready, mem_q,
        output mem_rd, mem_wr, mem_rfsh, mem_a, mem_d,
        input  p0_req, p0_a,
        output p0_q, p0_ack,
        input  p1_req, p1_we, p1_a, p1_d,
        output p1_q, p1_ack,
        output busy
    );

    modport slave (
        output mem_ready, mem_q,
        input  mem_rd, mem_wr, mem_rfsh, mem_a, mem_d,
        output p0_req, p0_a,
        input  p0_q, p0_ack,
        output p1_req, p1_we, p1_a, p1_d,
        input  p1_q, p1_ack,
        input  busy
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Shares one sdram controller between a read-only video port (p0) and a read/write CPU
// port (p1), interleaving periodic auto-refresh slots at highest priority.
module sdram_arbiter #(
    parameter int REFRESH_PERIOD = 390,
    parameter int STROBE_CYCLES  = 4,
    parameter int ACCESS_CYCLES  = 8,
    parameter int REFRESH_CYCLES = 12
) (
    input  logic             clock,
    input  logic             reset,
    sdram_arbiter_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        REFRESH,
        DONE
    } state_t;

    localparam int SLOT_MAX = (ACCESS_CYCLES > REFRESH_CYCLES) ? ACCESS_CYCLES : REFRESH_CYCLES;
    localparam int CNT_W    = (SLOT_MAX > 2) ? $clog2(SLOT_MAX) + 1 : 2;
    localparam int RF_W     = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD + 1) : 1;

    localparam logic [CNT_W-1:0] ACC_LAST  = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] RF_LAST   = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [CNT_W-1:0] STB_LIMIT = CNT_W'(STROBE_CYCLES);
    localparam logic [RF_W-1:0]  RF_RELOAD = RF_W'(REFRESH_PERIOD - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] slot_cnt;
    logic [RF_W-1:0]  rf_cnt;
    logic             rf_tick;
    logic             pending;

    logic             port_q;   // 0 = p0, 1 = p1
    logic             we_q;
    logic [23:0]      mem_a_q;
    logic [15:0]      mem_d_q;
    logic [15:0]      p0_q_q;
    logic [15:0]      p1_q_q;

    logic             grant_rf;
    logic             grant_p0;
    logic             grant_p1;
    logic             slot_last;
    logic             strobe_on;

    assign rf_tick   = (rf_cnt == '0);
    assign strobe_on = (slot_cnt < STB_LIMIT);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        grant_rf  = 1'b0;
        grant_p0  = 1'b0;
        grant_p1  = 1'b0;
        slot_last = (state_q == REFRESH) ? (slot_cnt == RF_LAST) : (slot_cnt == ACC_LAST);

        unique case (state_q)
            IDLE: begin
                if (bus.mem_ready) begin
                    if (pending) begin
                        grant_rf = 1'b1;
                        state_d  = REFRESH;
                    end else if (bus.p0_req) begin
                        grant_p0 = 1'b1;
                        state_d  = ACCESS;
                    end else if (bus.p1_req) begin
                        grant_p1 = 1'b1;
                        state_d  = ACCESS;
                    end
                end
            end
            ACCESS:  if (slot_last) state_d = DONE;
            REFRESH: if (slot_last) state_d = IDLE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            slot_cnt <= '0;
            rf_cnt   <= RF_RELOAD;
            pending  <= 1'b0;
            port_q   <= 1'b0;
            we_q     <= 1'b0;
            mem_a_q  <= '0;
            mem_d_q  <= '0;
            p0_q_q   <= '0;
            p1_q_q   <= '0;
        end else begin
            state_q <= state_d;
            rf_cnt  <= rf_tick ? RF_RELOAD : rf_cnt - 1'b1;
            // A tick coinciding with a refresh grant is a fresh request, so set wins over clear.
            pending <= rf_tick | (pending & ~grant_rf);

            if (state_q == ACCESS || state_q == REFRESH) begin
                slot_cnt <= slot_cnt + 1'b1;
            end else begin
                slot_cnt <= '0;
            end

            if (grant_p0 || grant_p1) begin
                port_q  <= grant_p1;
                we_q    <= grant_p1 & bus.p1_we;
                mem_a_q <= grant_p1 ? bus.p1_a : bus.p0_a;
                mem_d_q <= grant_p1 ? bus.p1_d : 16'h0000;
            end

            if (state_q == ACCESS && slot_last && !we_q) begin
                if (port_q) begin
                    p1_q_q <= bus.mem_q;
                end else begin
                    p0_q_q <= bus.mem_q;
                end
            end
        end
    end

    // Strobes decode registered state only, so they drop the cycle after a reset or slot end.
    assign bus.mem_rd   = (state_q == ACCESS)  && !we_q && strobe_on;
    assign bus.mem_wr   = (state_q == ACCESS)  &&  we_q && strobe_on;
    assign bus.mem_rfsh = (state_q == REFRESH) && strobe_on;
    assign bus.mem_a    = mem_a_q;
    assign bus.mem_d    = mem_d_q;

    assign bus.p0_q     = p0_q_q;
    assign bus.p1_q     = p1_q_q;
    assign bus.p0_ack   = (state_q == DONE) && !port_q;
    assign bus.p1_ack   = (state_q == DONE) &&  port_q;
    assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: one instance with the default refresh period for
// access traffic, and one with REFRESH_PERIOD=20 that only ever refreshes.
module tb_sdram_arbiter;

    logic clock;
    logic reset;

    int n_cmp = 0;
    int n_bad = 0;

    sdram_arbiter_if bus_m ();
    sdram_arbiter_if bus_r ();

    sdram_arbiter u_main (
        .clock (clock),
        .reset (reset),
        .bus   (bus_m)
    );

    sdram_arbiter #(.REFRESH_PERIOD(20)) u_rf (
        .clock (clock),
        .reset (reset),
        .bus   (bus_r)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Controller model: 256 words indexed by the low address byte, preset to {C0, index}.
    logic [15:0] model_mem [256];

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) model_mem[i] <= {8'hC0, 8'(i)};
        end else if (bus_m.mem_wr) begin
            model_mem[bus_m.mem_a[7:0]] <= bus_m.mem_d;
        end
    end

    assign bus_m.mem_q = model_mem[bus_m.mem_a[7:0]];
    assign bus_r.mem_q = 16'h0000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Called in the grant cycle G with the request already high; ends at G+9 with req dropped.
    task automatic check_slot(input bit port, input bit we, input logic [23:0] a,
                              input logic [15:0] d, input logic [15:0] q);
        logic [2:0] stb_exp;
        logic [1:0] ack_exp;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clock);
            stb_exp = 3'b000;
            if (k <= 4) stb_exp = we ? 3'b010 : 3'b100;
            ack_exp = (k == 9) ? (port ? 2'b01 : 2'b10) : 2'b00;
            check($sformatf("strobe@%0d", k), {bus_m.mem_rd, bus_m.mem_wr, bus_m.mem_rfsh}, stb_exp);
            check($sformatf("ack@%0d", k), {bus_m.p0_ack, bus_m.p1_ack}, ack_exp);
            check($sformatf("busy@%0d", k), bus_m.busy, 1);
            if (k < 9) begin
                check($sformatf("mem_a@%0d", k), bus_m.mem_a, a);
                check($sformatf("mem_d@%0d", k), bus_m.mem_d, d);
            end else begin
                if (port) begin
                    check("p1_q", bus_m.p1_q, q);
                    bus_m.p1_req = 1'b0;
                end else begin
                    check("p0_q", bus_m.p0_q, q);
                    bus_m.p0_req = 1'b0;
                end
            end
        end
    endtask

    initial begin
        logic rf_exp;
        logic busy_exp;

        reset           = 1'b0;
        bus_m.mem_ready = 1'b0;
        bus_m.p0_req    = 1'b0;
        bus_m.p0_a      = 24'h000000;
        bus_m.p1_req    = 1'b1;
        bus_m.p1_we     = 1'b1;
        bus_m.p1_a      = 24'h123456;
        bus_m.p1_d      = 16'hBEEF;

        bus_r.mem_ready = 1'b1;
        bus_r.p0_req    = 1'b0;
        bus_r.p0_a      = 24'h000000;
        bus_r.p1_req    = 1'b0;
        bus_r.p1_we     = 1'b0;
        bus_r.p1_a      = 24'h000000;
        bus_r.p1_d      = 16'h0000;

        do_reset();

        check("m_reset_a", bus_m.mem_a, 24'h000000);
        check("m_reset_d", bus_m.mem_d, 16'h0000);
        check("m_reset_q", {bus_m.p0_q, bus_m.p1_q}, 32'h0);

        // Refresh-only instance: tick at c19, grant c20, rfsh c21..c24, slot ends c32, every 20.
        // Meanwhile the main instance holds p1_req with mem_ready low and must stay quiet.
        for (int k = 0; k <= 62; k++) begin
            if (k > 0) @(negedge clock);
            rf_exp   = (k >= 21) && (((k - 1) % 20) < 4);
            busy_exp = (k >= 21) && (((k - 1) % 20) < 12);
            check($sformatf("r_rfsh@%0d", k), bus_r.mem_rfsh, rf_exp);
            check($sformatf("r_busy@%0d", k), bus_r.busy, busy_exp);
            check($sformatf("r_ack@%0d", k), {bus_r.p0_ack, bus_r.p1_ack, bus_r.mem_rd, bus_r.mem_wr}, 0);
            check($sformatf("m_quiet@%0d", k),
                  {bus_m.busy, bus_m.mem_rd, bus_m.mem_wr, bus_m.mem_rfsh, bus_m.p0_ack, bus_m.p1_ack}, 0);
        end

        // Ready rises: p1 write 0x123456 <= 0xBEEF is granted this cycle; p1_q stays 0.
        bus_m.mem_ready = 1'b1;
        check_slot(1'b1, 1'b1, 24'h123456, 16'hBEEF, 16'h0000);

        @(negedge clock);
        check("idle_after_wr", bus_m.busy, 0);

        // Read back the same address through the model.
        bus_m.p1_we  = 1'b0;
        bus_m.p1_req = 1'b1;
        check_slot(1'b1, 1'b0, 24'h123456, 16'hBEEF, 16'hBEEF);

        @(negedge clock);
        check("idle_after_rd", bus_m.busy, 0);

        // Simultaneous p0 and p1: p0 first, p1 granted at G+10, acked at G+19.
        bus_m.p0_a   = 24'h0A0011;
        bus_m.p1_a   = 24'h000022;
        bus_m.p0_req = 1'b1;
        bus_m.p1_req = 1'b1;
        check_slot(1'b0, 1'b0, 24'h0A0011, 16'h0000, 16'hC011);
        @(negedge clock);
        check("p1_wait", {bus_m.busy, bus_m.p1_ack, bus_m.mem_rd}, 0);
        check_slot(1'b1, 1'b0, 24'h000022, 16'hBEEF, 16'hC022);

        // Reset at slot count 3 of a p1 read.
        @(negedge clock);
        do_reset();
        bus_m.p1_a   = 24'h123456;
        bus_m.p1_req = 1'b1;
        for (int k = 1; k <= 4; k++) @(negedge clock);
        check("cnt3_rd", bus_m.mem_rd, 1);
        reset = 1'b1;
        @(negedge clock);
        check("abort_strobes", {bus_m.mem_rd, bus_m.mem_wr, bus_m.mem_rfsh}, 0);
        check("abort_busy", bus_m.busy, 0);
        check("abort_ack", {bus_m.p0_ack, bus_m.p1_ack}, 0);
        check("abort_a", bus_m.mem_a, 24'h000000);
        reset        = 1'b0;
        bus_m.p1_req = 1'b0;
        // This cycle is c0: refresh counter reloaded, tick due at c389, pending from c390.
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            check($sformatf("post_abort@%0d", k), {bus_m.busy, bus_m.p0_ack, bus_m.p1_ack}, 0);
        end
        repeat (375) @(negedge clock);

        // c385: p1 read whose slot (c386..c393) straddles the refresh tick.
        bus_m.p1_req = 1'b1;
        check_slot(1'b1, 1'b0, 24'h123456, 16'hBEEF, 16'hC056);
        bus_m.p0_req = 1'b1;
        bus_m.p0_a   = 24'h0A0011;

        @(negedge clock);
        check("rf_grant_idle", {bus_m.busy, bus_m.mem_rd, bus_m.mem_rfsh}, 0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            check($sformatf("rf_strobe@%0d", k), {bus_m.mem_rd, bus_m.mem_wr, bus_m.mem_rfsh},
                  (k <= 4) ? 3'b001 : 3'b000);
            check($sformatf("rf_busy@%0d", k), {bus_m.busy, bus_m.p0_ack, bus_m.p1_ack}, 3'b100);
        end
        @(negedge clock);
        check("p0_grant_idle", bus_m.busy, 0);
        check_slot(1'b0, 1'b0, 24'h0A0011, 16'h0000, 16'hC011);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
